// File: rtl/multicycle_ctrl_fsm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// riscv_ctrl_pkg : shared state/opcode/select encodings for the RV32I control
// Revision: 1.0
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore output table; anything not set for a state stays 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.adr_src = 1'b0; c.ir_write = 1'b1; c.pc_update = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
        c.alu_op = ALUOP_ADD; c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT; c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA; c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT; c.adr_src = 1'b1; c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT; c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_SUB;
        c.result_src = RES_ALUOUT; c.branch = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD;
        c.result_src = RES_ALUOUT; c.pc_update = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(state_t s, logic [6:0] op, logic trap);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECR;
          OP_I:         n = S_EXECI;
          OP_BEQ:       n = S_BEQ;
          OP_JAL:       n = S_JAL;
          default:      n = trap ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  n = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      n = S_ALUWB;
      S_ILLEGAL:  n = S_ILLEGAL;
      // MEMWB, MEMWRITE, ALUWB, BEQ and the unused codes all return to FETCH
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// multicycle_ctrl_fsm_if : opcode/flag inputs and datapath controls of the FSM
// Revision: 1.0
// ============================================================================
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    output op, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, illegal, state_dbg
  );

  modport slave (
    input  op, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, illegal, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_instr_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// instr_dec : opcode -> immediate format select, independent of FSM state
// Revision: 1.0
// ============================================================================
module instr_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
      OP_JAL:      imm_src = IMM_J;
      default:     imm_src = IMM_I;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// multicycle_ctrl_fsm : Moore main controller for the multicycle RV32I datapath
// Revision: 1.0
// ============================================================================
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.slave  bus
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [1:0] imm_src;

  assign state_next = next_state(state, bus.op, ILLEGAL_TRAP);

  // Controls are registered from the next state so they line up with the state
  // register; reset loads the FETCH selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= state_next;
      ctrl  <= state_ctrl(state_next);
    end
  end

  instr_dec u_instr_dec (
    .op      (bus.op),
    .imm_src (imm_src)
  );

  // Write enables are masked by reset so they drop in the same delta it rises,
  // even though the FETCH values held in ctrl would assert them.
  assign bus.pc_write   = (ctrl.pc_update | (ctrl.branch & bus.zero)) & ~reset;
  assign bus.ir_write   = ctrl.ir_write  & ~reset;
  assign bus.mem_write  = ctrl.mem_write & ~reset;
  assign bus.reg_write  = ctrl.reg_write & ~reset;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.result_src = ctrl.result_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.illegal    = ctrl.illegal;
  assign bus.imm_src    = imm_src;
  assign bus.state_dbg  = state;

endmodule
`default_nettype wire
